// File: rtl/pipe_rf_pkg.sv
// Shared constants and helpers for the pipeline register file and its
// busy-bit scoreboard.
package pipe_rf_pkg;

    // Default geometry of the classic 32 x 8 file this block replaces
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;

    // Widest address the decode helper supports; callers narrow the result
    localparam int MAX_ADDR_W = 6;
    localparam int MAX_REGS   = 2 ** MAX_ADDR_W;

    // One-hot decode of a register address. When zero_reg is set, r0 is
    // hardwired and never selected, so a decode of address 0 is all zeros.
    function automatic logic [MAX_REGS-1:0] addr_onehot(input int addr, input bit zero_reg);
        logic [MAX_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            if (i == addr) begin
                oh[i] = 1'b1;
            end
        end
        if (zero_reg) begin
            oh[0] = 1'b0;
        end
        return oh;
    endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// Bus between the decode/writeback side of the pipeline and the register
// file: read ports, writeback port, issue reservation, flush, busy count.
interface pipe_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    // Read ports, port k packed at [k*W +: W]
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    // Writeback port
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;

    // Destination reservation from decode
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;

    // Pipeline flush and scoreboard occupancy
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    // Pipeline side: drives addresses and strobes, observes data and hazards
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    // Register file side
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file. One bit per register marks an
// outstanding producer; decode reserves, writeback releases, flush clears.
// Exposes a per-read-port hazard flag and a registered busy count.
module rf_scoreboard
    import pipe_rf_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] iss_dec;
    logic [NUM_REGS-1:0] wr_dec;

    // Number of set bits in a busy vector
    function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Address decodes; a hardwired r0 never decodes, so it can never go busy
    always_comb begin
        iss_dec = NUM_REGS'(addr_onehot(int'(iss_addr), ZERO_REG != 0));
        wr_dec  = NUM_REGS'(addr_onehot(int'(wr_addr), ZERO_REG != 0));
    end

    // Next busy vector: flush beats issue, issue beats writeback release.
    // Release is applied first and the reservation OR'd on top, so an issue
    // and a writeback to the same register leave the bit set.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d = busy_d & ~wr_dec;
            end
            if (iss_en) begin
                busy_d = busy_d | iss_dec;
            end
        end
    end

    // Busy bits and their count advance together on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= popcount(busy_d);
        end
    end

    // Per-port hazard: a same-cycle writeback to the read register resolves
    // it, matching the data bypass on the read path
    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Hazard lookup for this port
        always_comb begin
            rd_busy[k] = busy_q[ra] & ~(wr_en & (wr_addr == ra));
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// Multi-read-port pipeline register file with write-through bypass,
// optional hardwired-zero r0 and an integrated busy-bit scoreboard for
// RAW hazard detection in decode.
module pipe_regfile
    import pipe_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_regfile_if.slave bus
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    // A write to a hardwired r0 is dropped entirely, including its bypass
    assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Register array: async clear, single posedge write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Combinational read ports
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;

        assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        // Port mux: reset forces zero, then hardwired r0, then the
        // writeback value in flight, then the stored register
        always_comb begin
            rdat = regs[ra];
            if (!rst_n) begin
                rdat = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rdat = '0;
            end else if (wr_ok && (bus.wr_addr == ra)) begin
                rdat = bus.wr_data;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = rdat;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (bus.rd_busy),
        .busy_cnt (bus.busy_cnt)
    );

endmodule

// File: doc/pipe_regfile.md
Name: pipe_regfile

Overview:
Parametrised multi-read-port register file for the MIPS pipeline, the successor to the current fixed 32x8 file. Adds a configurable read-port count, posedge writes with same-cycle write-through bypass, an optional hardwired-zero r0, and an integrated busy-bit scoreboard. The decode stage uses the scoreboard for RAW hazard detection. Sits between decode (reads, destination reservation) and writeback (writes, reservation release).

Parameters:
DATA_W, 8, data width of each register
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = r0 reads 0, ignores writes, never becomes busy; 0 = r0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port k's register has an outstanding reservation
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback value
iss_en  in  1  reserve destination register (instruction issued)
iss_addr  in  ADDR_W  register to reserve
flush  in  1  synchronous clear of all busy bits (pipeline flush); data untouched
busy_cnt  out  ADDR_W+1  number of currently busy registers

Behaviour:
- Reset (rst_n low, async): all NUM_REGS registers -> 0, all busy bits -> 0, busy_cnt -> 0. While rst_n is low, rd_data = 0 and rd_busy = 0 regardless of other inputs. wr_en and iss_en are ignored. Reset asserted mid-operation discards any in-flight write on that edge.
- Write: on posedge clk with wr_en=1, reg[wr_addr] <= wr_data. With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: combinational, zero latency. rd_data[k] = reg[rd_addr[k]]. If wr_en=1 and wr_addr==rd_addr[k] (and the target is not a hardwired r0), rd_data[k] = wr_data (write-through bypass). ZERO_REG=1 and rd_addr[k]=0 -> 0 always.
- Multiple ports may read the same address; all return identical values.
- Scoreboard, one busy bit per register, evaluated on posedge:
  - Priority: flush > iss_en > wr_en.
  - flush=1: all bits cleared, including any same-cycle issue.
  - iss_en=1: busy[iss_addr] <= 1 (ignored for r0 when ZERO_REG=1).
  - wr_en=1: busy[wr_addr] <= 0, unless iss_en=1 with iss_addr==wr_addr, in which case the bit stays 1 (new producer wins).
  - Issue to an already-busy register: stays 1, no error.
  - Writeback to a non-busy register: data written, bit stays 0.
- rd_busy[k] = busy[rd_addr[k]] & ~(wr_en & wr_addr==rd_addr[k]). A same-cycle writeback clears the hazard combinationally, consistent with the bypass. Always 0 for hardwired r0.
- busy_cnt: registered popcount of the busy vector, updated on the same edge as the busy bits; never exceeds NUM_REGS-ZERO_REG.
- No negedge logic; single clock domain.

Decomposition:
- Package pipe_rf_pkg: default DATA_W/ADDR_W constants, and a function returning a one-hot decode of an address with r0 masking controlled by ZERO_REG.
- Sub-module rf_scoreboard: busy vector, priority logic, popcount, per-port rd_busy lookup, parametrised by ADDR_W, NUM_RD, ZERO_REG.
- Data array, write logic and bypass muxes stay in pipe_regfile.

Test Plan:
- Reset: write r5=0xAA, assert rst_n low mid-cycle -> rd_data of r5 = 0 immediately; after release r5 reads 0x00 and busy_cnt = 0.
- Write-through: wr_en=1, wr_addr=7, wr_data=0x3C, rd_addr[0]=7 in the same cycle -> rd_data[0]=0x3C before the edge; after the edge, with wr_en=0, still 0x3C.
- Zero register (ZERO_REG=1): write r0=0xFF and issue r0 -> rd_data=0x00, rd_busy=0, busy_cnt unchanged; repeat with ZERO_REG=0 -> reads 0xFF, busy bit set.
- Scoreboard: issue r3; next cycle rd_addr[1]=3 -> rd_busy[1]=1, busy_cnt=1; writeback r3=0x11 that cycle -> rd_busy[1]=0 combinationally, busy_cnt=0 after the edge.
- Collision: same cycle iss_en r4 and wr_en r4=0x22 -> r4=0x22, busy[4] stays 1; next cycle flush=1 together with iss_en r9 -> all busy bits 0, busy_cnt=0.
- Multi-port (NUM_RD=4): all four ports read r2=0x5A -> all four return 0x5A; ports at distinct addresses return independent values.
